// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: fetch FSM states, FIFO entry layout, NOP encoding.
package rv32i_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      RESET = 1'b0,
      RUN   = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction FIFO with push, pop and clear; head is read straight from the
// storage flops, so it reflects a push on the cycle after it happens.
module fetch_fifo
   import rv32i_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         push,
   input  logic                         pop,
   input  logic [ENTRY_W-1:0]           push_data,
   output logic [ENTRY_W-1:0]           head,
   output logic                         head_valid,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Clear has priority over push and pop so a flush always leaves the FIFO empty.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // NOTE: storage has no reset; head_valid (count != 0) gates every read of it.
   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= push_data;
   end

   assign head       = mem[rd_ptr];
   assign head_valid = (count != '0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage instruction memory controller: single-outstanding requests, kill on redirect,
// instruction FIFO toward decode. Optional misaligned-PC faulting via IMEM_MISALIGN_CHECK_EN.
module imem_fetch_ctrl #(
   parameter int          DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_cur,
   input  logic        flush,
   input  logic        id_ready,
   output logic        StallF,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic        instr_valid,
   output logic        instr_fault
);

   import rv32i_pkg::*;

   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_t       state;
   fetch_state_t       state_nxt;
   logic               outstanding;
   logic               kill;
   logic [31:0]        inflight_pc;
   logic [CW-1:0]      count;
   logic [ENTRY_W-1:0] head_raw;
   fetch_entry_t       head;
   fetch_entry_t       push_entry;
   logic               head_valid;
   logic               pop;
   logic               room;
   logic               issue_ok;
   logic               misalign;
   logic               take_fault;
   logic               grant;
   logic               rsp_push;

   assign pop = id_ready && head_valid;

   // Occupancy counts the in-flight slot; pop implies count >= 1, so no underflow.
   assign room = ({1'b0, count} + (CW+1)'(outstanding) - (CW+1)'(pop)) < (CW+1)'(DEPTH);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      state_nxt = state;
      issue_ok  = 1'b0;
      case (state)
         RESET:   state_nxt = RUN;
         RUN:     issue_ok  = rst && !flush && (!outstanding || imem_rvalid) && room;
         default: state_nxt = RESET;
      endcase
   end

`ifdef IMEM_MISALIGN_CHECK_EN
   assign misalign = (pc_cur[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   // A fault entry waits for an idle port so it never competes with a response push.
   assign take_fault = issue_ok && misalign && !outstanding;
   assign imem_req   = issue_ok && !misalign;
   assign imem_addr  = {pc_cur[31:2], 2'b00};
   assign grant      = imem_req && imem_gnt;
   assign StallF     = !rst || (!(grant || take_fault) && !flush);

   assign rsp_push   = imem_rvalid && outstanding && !kill;
   assign push_entry = take_fault ? '{instr: NOP_INSTR, pc: pc_cur, fault: 1'b1}
                                  : '{instr: imem_rdata, pc: inflight_pc, fault: 1'b0};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= RESET;
         outstanding <= 1'b0;
         kill        <= 1'b0;
         inflight_pc <= '0;
      end else begin
         state <= state_nxt;
         if (grant)            outstanding <= 1'b1;
         else if (imem_rvalid) outstanding <= 1'b0;
         if (grant) inflight_pc <= pc_cur;
         // A response returning in the flush cycle is already discarded by the clear.
         if (flush && ((outstanding && !imem_rvalid) || grant)) kill <= 1'b1;
         else if (imem_rvalid && outstanding)                   kill <= 1'b0;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .clear      (flush),
      .push       (rsp_push || take_fault),
      .pop        (pop),
      .push_data  (push_entry),
      .head       (head_raw),
      .head_valid (head_valid),
      .count      (count)
   );

   assign head        = fetch_entry_t'(head_raw);
   assign instr_valid = head_valid;
   assign instr_d     = head_valid ? head.instr : NOP_INSTR;
   assign pc_d        = head_valid ? head.pc : 32'h0;
   assign instr_fault = head_valid && head.fault;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: the bench plays PC register and instruction
// memory, and checks the delivered stream against the sequential-PC rule.
module tb_imem_fetch_ctrl;

   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_cur;
   logic        flush;
   logic        id_ready;
   logic        StallF;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic        instr_valid;
   logic        instr_fault;

   int vectors     = 0;
   int miscompares = 0;

   // environment and model state
   logic [31:0] flush_target = '0;
   int          lat_min      = 1;
   int          lat_max      = 1;
   logic        mem_pending  = 1'b0;
   int          mem_wait     = 0;
   logic [31:0] mem_addr     = '0;
   logic [31:0] exp_pc       = '0;
   logic        chk_stall    = 1'b1;
   int          pop_count    = 0;

   // what the DUT showed in the most recent step
   logic        obs_req, obs_stall, obs_valid, obs_fault;
   logic [31:0] obs_addr, obs_instr, obs_pc;

   imem_fetch_ctrl #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_cur      (pc_cur),
      .flush       (flush),
      .id_ready    (id_ready),
      .StallF      (StallF),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_d     (instr_d),
      .pc_d        (pc_d),
      .instr_valid (instr_valid),
      .instr_fault (instr_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // One clock cycle: memory answers, outputs are sampled mid-cycle and checked against
   // the stream rule, then PC register and memory model advance after the edge.
   task automatic step();
      logic rv, grant, pop, exp_stall;
      @(negedge clk);
      rv          = mem_pending && (mem_wait == 0);
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_word(mem_addr) : 32'hDEAD_BEEF;
      #1;
      obs_req   = imem_req;    obs_addr  = imem_addr;  obs_stall = StallF;
      obs_valid = instr_valid; obs_instr = instr_d;    obs_pc    = pc_d;
      obs_fault = instr_fault;
      grant = imem_req && imem_gnt;
      pop   = instr_valid && id_ready && !flush && rst;
      if (obs_valid) begin
         if (!obs_fault) begin
            vectors++;
            if (obs_instr !== mem_word(obs_pc)) begin
               miscompares++;
               $display("FAIL head_data: instr_d=%h expected %h (pc_d=%h)", obs_instr, mem_word(obs_pc), obs_pc);
            end
         end
         if (pop) begin
            vectors++;
            pop_count++;
            if (obs_pc !== exp_pc) begin
               miscompares++;
               $display("FAIL stream_pc: pc_d=%h expected %h", obs_pc, exp_pc);
            end
         end
      end else begin
         vectors++;
         if (obs_instr !== NOP || obs_pc !== 32'h0 || obs_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_head: instr_d=%h pc_d=%h fault=%b expected %h/0/0", obs_instr, obs_pc, obs_fault, NOP);
         end
      end
`ifndef IMEM_MISALIGN_CHECK_EN
      vectors++;
      if (obs_fault !== 1'b0) begin
         miscompares++;
         $display("FAIL fault_tied: instr_fault=%b expected 0", obs_fault);
      end
`endif
      if (obs_req) begin
         vectors++;
         if (obs_addr !== {pc_cur[31:2], 2'b00}) begin
            miscompares++;
            $display("FAIL req_addr: imem_addr=%h expected %h", obs_addr, {pc_cur[31:2], 2'b00});
         end
      end
      if (grant) begin
         vectors++;
         if (mem_pending && !rv) begin
            miscompares++;
            $display("FAIL single_outstanding: grant at %h while %h still in flight", obs_addr, mem_addr);
         end
      end
      if (chk_stall) begin
         exp_stall = !rst || (!grant && !flush);
         vectors++;
         if (obs_stall !== exp_stall) begin
            miscompares++;
            $display("FAIL stallf: StallF=%b expected %b", obs_stall, exp_stall);
         end
      end
      @(posedge clk);
      #1;
      if (rv) mem_pending = 1'b0;
      else if (mem_pending) mem_wait--;
      if (grant) begin
         mem_pending = 1'b1;
         mem_wait    = int'($urandom_range(lat_max, lat_min)) - 1;
         mem_addr    = obs_addr;
      end
      if (!rst) begin
         pc_cur = '0;
         exp_pc = '0;
      end else if (flush) begin
         pc_cur = flush_target;
         exp_pc = flush_target;
      end else begin
         if (!obs_stall) pc_cur = pc_cur + 32'd4;
         if (pop)        exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic drain();
      flush = 1'b0; imem_gnt = 1'b0; id_ready = 1'b1;
      repeat (6) step();
   endtask

   task automatic test_reset();
      rst = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1;
      repeat (3) begin
         step();
         vectors++;
         if (obs_req !== 1'b0 || obs_valid !== 1'b0 || obs_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs: req=%b valid=%b StallF=%b expected 0/0/1", obs_req, obs_valid, obs_stall);
         end
      end
   endtask

   task automatic test_startup();
      int first = -1;
      logic [31:0] first_pc = '1;
      rst = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1; lat_min = 1; lat_max = 1;
      step();
      vectors++;
      if (obs_req !== 1'b0 || obs_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_state_cycle: req=%b StallF=%b expected 0/1", obs_req, obs_stall);
      end
      for (int i = 1; i <= 8; i++) begin
         step();
         if (obs_valid && first < 0) begin
            first    = i;
            first_pc = obs_pc;
         end
         vectors++;
         if (obs_stall !== 1'b0 || (i >= 3 && obs_valid !== 1'b1)) begin
            miscompares++;
            $display("FAIL startup_stream: cycle %0d StallF=%b valid=%b expected 0/%b", i, obs_stall, obs_valid, i >= 3);
         end
      end
      vectors++;
      if (first !== 3 || first_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL first_valid: cycle %0d pc_d=%h expected cycle 3 pc_d=0", first, first_pc);
      end
   endtask

   task automatic test_backpressure();
      int n = 0;
      id_ready = 1'b0; imem_gnt = 1'b1;
      repeat (8) step();
      vectors++;
      if (obs_req !== 1'b0 || obs_stall !== 1'b1 || obs_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL full_hold: req=%b StallF=%b valid=%b expected 0/1/1", obs_req, obs_stall, obs_valid);
      end
      imem_gnt = 1'b0; id_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (!obs_valid) break;
         n++;
      end
      vectors++;
      if (n !== DEPTH) begin
         miscompares++;
         $display("FAIL buffered_count: %0d entries expected %0d", n, DEPTH);
      end
      imem_gnt = 1'b1;
      repeat (3) step();
      for (int i = 0; i < 10; i++) begin
         step();
         vectors++;
         if (obs_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL throughput: gap at cycle %0d valid=%b expected 1", i, obs_valid);
         end
      end
   endtask

   task automatic test_flush();
      int seen = 0;
      drain();
      flush = 1'b1; flush_target = 32'h20; lat_min = 3; lat_max = 3;
      step();
      flush = 1'b0; imem_gnt = 1'b1;
      step();
      vectors++;
      if (obs_req !== 1'b1 || obs_addr !== 32'h20) begin
         miscompares++;
         $display("FAIL grant_0x20: req=%b addr=%h expected 1/00000020", obs_req, obs_addr);
      end
      lat_min = 1; lat_max = 1;
      flush = 1'b1; flush_target = 32'h100;
      step();
      flush = 1'b0;
      step();
      vectors++;
      if (obs_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_empty: valid=%b expected 0", obs_valid);
      end
      for (int i = 0; i < 10 && seen == 0; i++) begin
         step();
         if (obs_valid) begin
            seen = 1;
            vectors++;
            if (obs_pc !== 32'h100) begin
               miscompares++;
               $display("FAIL redirect_pc: pc_d=%h expected 00000100", obs_pc);
            end
         end
      end
      vectors++;
      if (seen !== 1) begin
         miscompares++;
         $display("FAIL redirect_timeout: no valid entry within 10 cycles, expected one");
      end
   endtask

   task automatic test_gnt_stall();
      drain();
      flush = 1'b1; flush_target = 32'h40; id_ready = 1'b0;
      step();
      flush = 1'b0; imem_gnt = 1'b0;
      repeat (3) begin
         step();
         vectors++;
         if (obs_stall !== 1'b1 || obs_req !== 1'b1 || obs_addr !== 32'h40) begin
            miscompares++;
            $display("FAIL gnt_wait: StallF=%b req=%b addr=%h expected 1/1/00000040", obs_stall, obs_req, obs_addr);
         end
      end
      imem_gnt = 1'b1;
      step();
      vectors++;
      if (obs_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL gnt_accept: StallF=%b expected 0", obs_stall);
      end
      imem_gnt = 1'b0;
      repeat (3) step();
      vectors++;
      if (obs_valid !== 1'b1 || obs_pc !== 32'h40) begin
         miscompares++;
         $display("FAIL gnt_entry: valid=%b pc_d=%h expected 1/00000040", obs_valid, obs_pc);
      end
      id_ready = 1'b1;
      step();
      step();
      vectors++;
      if (obs_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_entry: valid=%b expected 0", obs_valid);
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      drain();
      flush = 1'b1; flush_target = 32'h200; id_ready = 1'b0;
      step();
      flush = 1'b0; imem_gnt = 1'b1; lat_min = 3; lat_max = 3;
      repeat (5) step();
      vectors++;
      if (obs_valid !== 1'b1 || obs_pc !== 32'h200) begin
         miscompares++;
         $display("FAIL pre_reset_buffer: valid=%b pc_d=%h expected 1/00000200", obs_valid, obs_pc);
      end
      rst = 1'b0;
      step();
      rst = 1'b1; lat_min = 1; lat_max = 1;
      step();
      vectors++;
      if (obs_valid !== 1'b0 || obs_instr !== NOP || obs_pc !== 32'h0 || obs_req !== 1'b0 || obs_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_reset_values: valid=%b instr=%h pc=%h req=%b StallF=%b expected 0/%h/0/0/1",
                  obs_valid, obs_instr, obs_pc, obs_req, obs_stall, NOP);
      end
      step();
      vectors++;
      if (obs_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL late_rvalid: valid=%b expected 0", obs_valid);
      end
      id_ready = 1'b1;
      for (int i = 0; i < 10 && seen == 0; i++) begin
         step();
         if (obs_valid) begin
            seen = 1;
            vectors++;
            if (obs_pc !== 32'h0) begin
               miscompares++;
               $display("FAIL restart_pc: pc_d=%h expected 00000000", obs_pc);
            end
         end
      end
      vectors++;
      if (seen !== 1) begin
         miscompares++;
         $display("FAIL restart_timeout: no valid entry within 10 cycles, expected one");
      end
   endtask

`ifdef IMEM_MISALIGN_CHECK_EN
   task automatic test_misalign();
      drain();
      flush = 1'b1; flush_target = 32'h42; id_ready = 1'b0;
      step();
      flush = 1'b0; imem_gnt = 1'b1; chk_stall = 1'b0;
      step();
      vectors++;
      if (obs_req !== 1'b0 || obs_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL misalign_issue: req=%b StallF=%b expected 0/0", obs_req, obs_stall);
      end
      step();
      vectors++;
      if (obs_valid !== 1'b1 || obs_fault !== 1'b1 || obs_pc !== 32'h42 || obs_instr !== NOP) begin
         miscompares++;
         $display("FAIL misalign_entry: valid=%b fault=%b pc=%h instr=%h expected 1/1/00000042/%h",
                  obs_valid, obs_fault, obs_pc, obs_instr, NOP);
      end
      flush = 1'b1; flush_target = 32'h300;
      step();
      flush = 1'b0; chk_stall = 1'b1;
   endtask
`endif

   task automatic test_random();
      int start = pop_count;
      lat_min = 1; lat_max = 3;
      for (int i = 0; i < 400; i++) begin
         id_ready     = ($urandom_range(0, 3) != 0);
         imem_gnt     = ($urandom_range(0, 3) != 0);
         flush        = ($urandom_range(0, 24) == 0);
         flush_target = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         step();
      end
      flush = 1'b0;
      vectors++;
      if (pop_count - start < 40) begin
         miscompares++;
         $display("FAIL random_progress: %0d instructions delivered expected at least 40", pop_count - start);
      end
   endtask

   initial begin
      rst = 1'b0; pc_cur = '0; flush = 1'b0; id_ready = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      test_reset();
      test_startup();
      test_backpressure();
      test_flush();
      test_gnt_stall();
      test_reset_mid();
`ifdef IMEM_MISALIGN_CHECK_EN
      test_misalign();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

endmodule
